// File: rtl/lab2_proc_muldiv_iter.sv
// Iterative multiply/divide unit: one bit per cycle over W cycles, with a
// valid/ready request port and a valid/ready response port.
module lab2_proc_muldiv_iter #(
  parameter int W  = 32,
  parameter int CW = $clog2(W+1)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_val,
  output logic         req_rdy,
  input  logic [2:0]   req_fn,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_val,
  input  logic         resp_rdy,
  output logic [W-1:0] resp_msg
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    fn_q, fn_d;
  logic [W-1:0]  a_q, a_d;          // multiplicand, or dividend shifting into quotient
  logic [W-1:0]  b_q, b_d;          // multiplier, or divisor magnitude
  logic [W:0]    acc_q, acc_d;      // product accumulator, or partial remainder
  logic [W-1:0]  result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;

  logic          div_mode;
  logic [W:0]    rem_shift;
  logic [W:0]    acc_step;
  logic [W-1:0]  a_step;
  logic [W-1:0]  b_step;
  logic [W-1:0]  final_res;

  // One iteration of either shift-add multiply or restoring division.
  always_comb begin
    div_mode  = fn_q inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
    rem_shift = {acc_q[W-1:0], a_q[W-1]};
    acc_step  = acc_q;
    a_step    = a_q;
    b_step    = b_q;
    if (div_mode) begin
      if (rem_shift >= {1'b0, b_q}) begin
        acc_step = rem_shift - {1'b0, b_q};
        a_step   = {a_q[W-2:0], 1'b1};
      end else begin
        acc_step = rem_shift;
        a_step   = {a_q[W-2:0], 1'b0};
      end
    end else begin
      acc_step = acc_q + (b_q[0] ? {1'b0, a_q} : '0);
      a_step   = a_q << 1;
      b_step   = b_q >> 1;
    end
  end

  // Result formed from the last iteration's outputs, with sign correction.
  // A zero divisor yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    final_res = '0;
    case (fn_q)
      FN_MUL:  final_res = acc_step[W-1:0];
      FN_DIV:  final_res = (b_q == '0) ? '1 : (neg_quo_q ? -a_step : a_step);
      FN_DIVU: final_res = a_step;
      FN_REM:  final_res = neg_rem_q ? -acc_step[W-1:0] : acc_step[W-1:0];
      FN_REMU: final_res = acc_step[W-1:0];
      default: final_res = '0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    state_d   = state_q;
    fn_d      = fn_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      IDLE: begin
        if (req_val) begin
          state_d  = CALC;
          fn_d     = req_fn;
          acc_d    = '0;
          result_d = '0;
          cnt_d    = CW'(W);
          if (req_fn == FN_DIV || req_fn == FN_REM) begin
            a_d       = magnitude(req_a);
            b_d       = magnitude(req_b);
            neg_quo_d = req_a[W-1] ^ req_b[W-1];
            neg_rem_d = req_a[W-1];
          end else begin
            a_d       = req_a;
            b_d       = req_b;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
          end
        end
      end
      CALC: begin
        a_d   = a_step;
        b_d   = b_step;
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_d  = IDLE;
          result_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears all state; sequential updates use <= only.
    if (!reset_n) begin
      state_q   <= IDLE;
      fn_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fn_q      <= fn_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign req_rdy  = (state_q == IDLE);
  assign resp_val = (state_q == DONE);
  assign resp_msg = resp_val ? result_q : '0;

endmodule

// File: tb/tb_lab2_proc_muldiv_iter.sv
// Directed and model-checked bench for lab2_proc_muldiv_iter at W = 8, 32, 64.
module tb_lab2_proc_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        val_s [3];
  logic [2:0]  fn_s  [3];
  logic [63:0] a_s   [3];
  logic [63:0] b_s   [3];
  logic        rr_s  [3];
  logic        rdy_s [3];
  logic        rv_s  [3];
  logic [7:0]  m8;
  logic [31:0] m32;
  logic [63:0] m64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lab2_proc_muldiv_iter #(.W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .req_val(val_s[0]), .req_rdy(rdy_s[0]),
    .req_fn(fn_s[0]), .req_a(a_s[0][7:0]), .req_b(b_s[0][7:0]),
    .resp_val(rv_s[0]), .resp_rdy(rr_s[0]), .resp_msg(m8)
  );

  lab2_proc_muldiv_iter #(.W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .req_val(val_s[1]), .req_rdy(rdy_s[1]),
    .req_fn(fn_s[1]), .req_a(a_s[1][31:0]), .req_b(b_s[1][31:0]),
    .resp_val(rv_s[1]), .resp_rdy(rr_s[1]), .resp_msg(m32)
  );

  lab2_proc_muldiv_iter #(.W(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .req_val(val_s[2]), .req_rdy(rdy_s[2]),
    .req_fn(fn_s[2]), .req_a(a_s[2]), .req_b(b_s[2]),
    .resp_val(rv_s[2]), .resp_rdy(rr_s[2]), .resp_msg(m64)
  );

  typedef struct {
    logic [2:0]  fn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [15];

  function automatic int width_of(input int d);
    case (d)
      0:       return 8;
      1:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic logic [63:0] msg_of(input int d);
    case (d)
      0:       return {56'd0, m8};
      1:       return {32'd0, m32};
      default: return m64;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference arithmetic built on native 64-bit operators.
  function automatic logic [63:0] golden(input int w, input logic [2:0] fn,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    logic [63:0] t;
    longint      sa;
    longint      sb;
    longint      mn;
    mask = mask_of(w);
    t  = a << (64 - w);
    sa = $signed(t) >>> (64 - w);
    t  = b << (64 - w);
    sb = $signed(t) >>> (64 - w);
    mn = longint'(64'd1 << (w - 1));
    mn = -mn;
    case (fn)
      3'd0: return (a * b) & mask;
      3'd1: begin
        if (b == 64'd0)            return mask;
        if (sa == mn && sb == -1)  return a;
        return 64'(sa / sb) & mask;
      end
      3'd2: return (b == 64'd0) ? mask : ((a / b) & mask);
      3'd3: begin
        if (b == 64'd0)            return a;
        if (sa == mn && sb == -1)  return 64'd0;
        return 64'(sa % sb) & mask;
      end
      3'd4: return (b == 64'd0) ? a : (a % b);
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input int d, input string name);
    check({name, "_rdy"}, 64'(rdy_s[d]), 64'd1);
    check({name, "_val"}, 64'(rv_s[d]), 64'd0);
    check({name, "_msg"}, msg_of(d), 64'd0);
  endtask

  // Issue one request, scramble the request inputs while busy, wait for the
  // response (bounded), consume it and confirm the return to IDLE.
  task automatic run_op(input int d, input logic [2:0] fn, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    int busy_rdy;
    busy_rdy = 0;
    lat      = 0;
    fn_s[d]  = fn;
    a_s[d]   = a;
    b_s[d]   = b;
    val_s[d] = 1'b1;
    tick();
    val_s[d] = 1'b0;
    fn_s[d]  = 3'($urandom);
    a_s[d]   = {$urandom, $urandom};
    b_s[d]   = {$urandom, $urandom};
    while (!rv_s[d] && lat < 200) begin
      if (rdy_s[d]) busy_rdy++;
      if (msg_of(d) != 64'd0) busy_rdy++;
      tick();
      lat++;
    end
    if (rdy_s[d]) busy_rdy++;
    res = msg_of(d);
    check("rdy_low_and_msg_zero_while_busy", 64'(busy_rdy), 64'd0);
    rr_s[d] = 1'b1;
    tick();
    rr_s[d] = 1'b0;
    check_idle(d, "after_resp");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] res;
    logic [63:0] first;
    int          lat;
    int          unstable;
    int          stray;

    vecs[0]  = '{3'd0, 64'hFFFFFFFD, 64'd7,        64'hFFFFFFEB, "mul_neg3_x7"};
    vecs[1]  = '{3'd1, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFD, "div_neg7_2"};
    vecs[2]  = '{3'd3, 64'hFFFFFFF9, 64'd2,        64'hFFFFFFFF, "rem_neg7_2"};
    vecs[3]  = '{3'd2, 64'hFFFFFFF9, 64'd2,        64'h7FFFFFFC, "divu_big_2"};
    vecs[4]  = '{3'd4, 64'hFFFFFFF9, 64'd2,        64'd1,        "remu_big_2"};
    vecs[5]  = '{3'd2, 64'd5,        64'd0,        64'hFFFFFFFF, "divu_by_zero"};
    vecs[6]  = '{3'd3, 64'd5,        64'd0,        64'd5,        "rem_by_zero"};
    vecs[7]  = '{3'd1, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, "div_overflow"};
    vecs[8]  = '{3'd3, 64'h80000000, 64'hFFFFFFFF, 64'd0,        "rem_overflow"};
    vecs[9]  = '{3'd0, 64'd6,        64'd7,        64'd42,       "mul_6x7"};
    vecs[10] = '{3'd5, 64'd3,        64'd4,        64'd0,        "reserved_fn5"};
    vecs[11] = '{3'd1, 64'd5,        64'd0,        64'hFFFFFFFF, "div_by_zero"};
    vecs[12] = '{3'd4, 64'd100,      64'd7,        64'd2,        "remu_100_7"};
    vecs[13] = '{3'd1, 64'd7,        64'hFFFFFFFE, 64'hFFFFFFFD, "div_7_neg2"};
    vecs[14] = '{3'd3, 64'd7,        64'hFFFFFFFE, 64'd1,        "rem_7_neg2"};

    // Reset with req_val already high: must come out idle, nothing accepted.
    for (int d = 0; d < 3; d++) begin
      val_s[d] = 1'b1;
      fn_s[d]  = 3'd0;
      a_s[d]   = 64'd3;
      b_s[d]   = 64'd3;
      rr_s[d]  = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) check_idle(d, "in_reset");
    for (int d = 0; d < 3; d++) val_s[d] = 1'b0;
    reset_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) check_idle(d, "post_reset");

    // Table-driven W=32 vectors.
    for (int i = 0; i < 15; i++) begin
      run_op(1, vecs[i].fn, vecs[i].a, vecs[i].b, res, lat);
      check(vecs[i].name, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd32);
    end

    // Backpressure: hold the response for 10 cycles while req_a wiggles.
    fn_s[1] = 3'd0; a_s[1] = 64'h1234; b_s[1] = 64'h10; val_s[1] = 1'b1;
    tick();
    val_s[1] = 1'b0;
    lat = 0;
    while (!rv_s[1] && lat < 200) begin
      tick();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'd32);
    first = msg_of(1);
    check("bp_value", first, 64'h12340);
    unstable = 0;
    for (int k = 0; k < 10; k++) begin
      a_s[1]   = {$urandom, $urandom};
      val_s[1] = k[0];
      tick();
      if (!rv_s[1] || rdy_s[1] || msg_of(1) != first) unstable++;
    end
    val_s[1] = 1'b0;
    check("bp_stable", 64'(unstable), 64'd0);
    rr_s[1] = 1'b1;
    tick();
    rr_s[1] = 1'b0;
    check_idle(1, "bp_release");

    // Reset during the 15th CALC cycle discards the operation.
    fn_s[1] = 3'd0; a_s[1] = 64'd9; b_s[1] = 64'd9; val_s[1] = 1'b1;
    tick();
    val_s[1] = 1'b0;
    repeat (14) tick();
    check("midcalc_busy", 64'(rdy_s[1]), 64'd0);
    reset_n = 1'b0;
    tick();
    check_idle(1, "midcalc_reset");
    reset_n = 1'b1;
    stray = 0;
    repeat (40) begin
      tick();
      if (rv_s[1] || !rdy_s[1]) stray++;
    end
    check("no_stale_resp", 64'(stray), 64'd0);
    run_op(1, 3'd0, 64'd6, 64'd7, res, lat);
    check("post_reset_mul", res, 64'd42);
    check("post_reset_mul_latency", 64'(lat), 64'd32);

    // W=8 and W=64 corner cases.
    run_op(0, 3'd1, 64'h80, 64'hFF, res, lat);
    check("w8_div_overflow", res, 64'h80);
    check("w8_div_latency", 64'(lat), 64'd8);
    run_op(0, 3'd0, 64'h10, 64'h10, res, lat);
    check("w8_mul_wrap", res, 64'h00);
    check("w8_mul_latency", 64'(lat), 64'd8);
    run_op(2, 3'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, res, lat);
    check("w64_div_overflow", res, 64'h8000_0000_0000_0000);
    check("w64_div_latency", 64'(lat), 64'd64);

    // Random operations against the reference model at every width.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 12; k++) begin
        logic [2:0]  fn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] mask;
        int          w;
        w    = width_of(d);
        mask = mask_of(w);
        fn   = 3'($urandom_range(0, 7));
        a    = {$urandom, $urandom} & mask;
        b    = {$urandom, $urandom} & mask;
        if (k % 4 == 0) b = b >> (w / 2 + 1);
        if (k % 5 == 3) b = 64'd0;
        if (k % 6 == 1) begin
          a  = 64'd1 << (w - 1);
          b  = mask;
          fn = (k % 12 == 1) ? 3'd1 : 3'd3;
        end
        run_op(d, fn, a, b, res, lat);
        check($sformatf("rand_w%0d_fn%0d_a%0h_b%0h", w, fn, a, b), res, golden(w, fn, a, b));
        check($sformatf("rand_w%0d_latency", w), 64'(lat), 64'(w));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lab2_proc_muldiv_iter.md
LAB2_PROC_MULDIV_ITER -- requirements
Module: lab2_proc_muldiv_iter

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand/result width in bits (legal: 8..64, even).
REQ-002 SHALL have parameter CW, default $clog2(W+1), meaning iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port req_val  input  1  request valid.
REQ-006 SHALL have port req_rdy  output  1  unit ready to accept a request.
REQ-007 SHALL have port req_fn  input  3  operation: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; 5-7 reserved.
REQ-008 SHALL have port req_a  input  W  operand 0 (multiplicand/dividend).
REQ-009 SHALL have port req_b  input  W  operand 1 (multiplier/divisor).
REQ-010 SHALL have port resp_val  output  1  response valid.
REQ-011 SHALL have port resp_rdy  input  1  consumer ready.
REQ-012 SHALL have port resp_msg  output  W  result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; req_rdy=1 only in IDLE; resp_val=1 only in DONE.
REQ-014 SHALL transition IDLE->CALC when req_val&&req_rdy, latching fn, operands, and operand signs, and loading counter with W.
REQ-015 SHALL stay in CALC exactly W cycles, processing one bit per cycle, decrementing counter; CALC->DONE when counter reaches 1.
REQ-016 SHALL stay in DONE, holding resp_msg stable, until resp_rdy=1; then go to IDLE.
REQ-017 SHALL give latency: request accepted at edge E -> resp_val high in the cycle after edge E+W; no new request accepted before return to IDLE (throughput one op per W+2 cycles minimum).
REQ-018 MUL SHALL return low W bits of a*b via shift-add (sign-independent).
REQ-019 DIV/REM SHALL operate on magnitudes via restoring division, then correct signs on the CALC->DONE edge: quotient negative iff signs differ; remainder takes the dividend's sign.
REQ-020 DIVU/REMU SHALL treat operands as unsigned.
REQ-021 Divide by zero SHALL return all-ones for DIV/DIVU and req_a for REM/REMU, still taking full W-cycle latency.
REQ-022 Signed overflow (a = most-negative, b = -1) SHALL return a for DIV and 0 for REM.
REQ-023 Reserved fn codes SHALL complete with normal latency and return 0.
REQ-024 Input changes on req_* while not in IDLE SHALL have no effect.
REQ-025 resp_msg SHALL be 0 whenever resp_val=0.

Reset
REQ-026 When reset_n=0 at a rising edge, state SHALL become IDLE, counter 0, all datapath registers 0, regardless of current state (including mid-CALC or DONE awaiting resp_rdy); the in-flight operation is discarded.
REQ-027 During and after reset: req_rdy=1, resp_val=0, resp_msg=0.
REQ-028 A req_val asserted in the same cycle as reset_n=0 SHALL NOT be accepted.

Verification (W=32 unless noted)
REQ-029 MUL a=0xFFFFFFFD(-3), b=7, accepted edge 0 -> resp_val rises after edge 32, resp_msg=0xFFFFFFEB; req_rdy=0 throughout CALC/DONE.
REQ-030 DIV a=-7, b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=0xFFFFFFF9, b=2 -> 0x7FFFFFFC; REMU -> 1.
REQ-031 Divide by zero: DIVU a=5,b=0 -> 0xFFFFFFFF; REM a=5,b=0 -> 5; overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 Backpressure: hold resp_rdy=0 for 10 cycles in DONE -> resp_val and resp_msg stable; resp_rdy=1 -> IDLE next cycle, req_rdy=1; changing req_a during wait has no effect.
REQ-033 Reset mid-CALC (reset_n=0 at CALC cycle 15) -> next cycle IDLE, resp_val=0; subsequent MUL 6*7 -> 42 with full latency.
REQ-034 Parameter sweep W=8: DIV 0x80/0xFF -> 0x80, MUL 0x10*0x10 -> 0x00, latency 8 CALC cycles; random signed/unsigned ops vs golden model for W=8,32,64.
